// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
// The FCS state exists only when GMII_TX_SCHED_FCS_EN is defined.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PAD     = 3'd3,
`ifdef GMII_TX_SCHED_FCS_EN
    ST_FCS     = 3'd4,
`endif
    ST_IFG     = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  // One byte of the bit-reflected Ethernet CRC, LSB of the data byte first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] poly_r;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) begin
      poly_r[i] = CRC32_POLY[31-i];
    end
    c = crc ^ {24'h000000, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide running CRC-32 register with synchronous clear and update enable.
// o_crc is the raw register; the caller applies the final inversion.
module eth_crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // CRC accumulator register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= CRC32_INIT;
    end else if (i_clr) begin
      r_crc <= CRC32_INIT;
    end else if (i_en) begin
      r_crc <= crc32_d8(r_crc, i_data);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/gmii_tx_sched.sv
// Two-source round-robin frame scheduler producing a GMII byte stream with
// preamble/SFD, zero padding and IFG. Define GMII_TX_SCHED_FCS_EN to append CRC-32 FCS.
module gmii_tx_sched
  import gmii_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12,
  parameter int MIN_PAYLOAD  = 60
) (
  input  logic       i_gmii_tx_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_ch0_data,
  input  logic       i_ch0_valid,
  input  logic       i_ch0_last,
  output logic       o_ch0_ready,
  input  logic [7:0] i_ch1_data,
  input  logic       i_ch1_valid,
  input  logic       i_ch1_last,
  output logic       o_ch1_ready,
  output logic [7:0] o_gmii_txd,
  output logic       o_gmii_tx_en,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_underrun
);

  state_t      r_state, w_state_nxt;
  logic        r_grant, w_grant_nxt;
  logic        r_rr_ptr, w_rr_ptr_nxt;
  logic [15:0] r_step, w_step_nxt;
  logic [10:0] r_byte_cnt, w_byte_cnt_nxt, w_byte_cnt_inc;
  logic [7:0]  r_txd, w_txd_nxt;
  logic        r_tx_en, w_tx_en_nxt;
  logic        r_tx_done, w_tx_done_nxt;
  logic        r_underrun, w_underrun_nxt;
  logic        r_ch0_ready, r_ch1_ready, r_busy;
  logic        w_xfer_nxt;
  logic        w_sel_valid, w_sel_last;
  logic [7:0]  w_sel_data;

  assign w_sel_valid    = r_grant ? i_ch1_valid : i_ch0_valid;
  assign w_sel_last     = r_grant ? i_ch1_last  : i_ch0_last;
  assign w_sel_data     = r_grant ? i_ch1_data  : i_ch0_data;
  assign w_byte_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : (r_byte_cnt + 11'd1);

`ifdef GMII_TX_SCHED_FCS_EN
  logic        w_crc_clr, w_crc_en;
  logic [31:0] w_crc;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_byte;

  assign w_crc_clr = (r_state == ST_IDLE) && (i_ch0_valid || i_ch1_valid);
  assign w_crc_en  = ((r_state == ST_PAYLOAD) && w_sel_valid) || (r_state == ST_PAD);
  assign w_fcs     = ~w_crc;

  eth_crc32_d8 u_crc (
    .i_clk   (i_gmii_tx_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_crc_clr),
    .i_en    (w_crc_en),
    .i_data  (w_txd_nxt),
    .o_crc   (w_crc)
  );

  // FCS goes out least-significant byte first.
  always_comb begin
    w_fcs_byte = 8'h00;
    case (r_step[1:0])
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      2'd3:    w_fcs_byte = w_fcs[31:24];
      default: w_fcs_byte = 8'h00;
    endcase
  end
`endif

  // Next-state logic; output fields hold the byte that appears on the bus next cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_step_nxt     = r_step;
    w_byte_cnt_nxt = r_byte_cnt;
    w_txd_nxt      = 8'h00;
    w_tx_en_nxt    = 1'b0;
    w_tx_done_nxt  = 1'b0;
    w_underrun_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_ch0_valid || i_ch1_valid) begin
          if (r_rr_ptr) begin
            w_grant_nxt = i_ch1_valid;
          end else begin
            w_grant_nxt = ~i_ch0_valid;
          end
          w_state_nxt    = ST_PRE;
          w_txd_nxt      = PREAMBLE_BYTE;
          w_tx_en_nxt    = 1'b1;
          w_step_nxt     = 16'd1;
          w_byte_cnt_nxt = 11'd0;
        end else begin
          w_step_nxt = 16'd0;
        end
      end
      ST_PRE: begin
        w_tx_en_nxt = 1'b1;
        if (r_step < 16'(PREAMBLE_LEN)) begin
          w_txd_nxt  = PREAMBLE_BYTE;
          w_step_nxt = r_step + 16'd1;
        end else begin
          w_txd_nxt   = SFD_BYTE;
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_sel_valid) begin
          w_txd_nxt      = w_sel_data;
          w_tx_en_nxt    = 1'b1;
          w_byte_cnt_nxt = w_byte_cnt_inc;
          if (w_sel_last) begin
            w_step_nxt = 16'd0;
            if (w_byte_cnt_inc < 11'(MIN_PAYLOAD)) begin
              w_state_nxt = ST_PAD;
            end else begin
`ifdef GMII_TX_SCHED_FCS_EN
              w_state_nxt = ST_FCS;
`else
              w_state_nxt   = ST_IFG;
              w_tx_done_nxt = 1'b1;
`endif
            end
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else begin
          w_underrun_nxt = 1'b1;
          w_state_nxt    = ST_DRAIN;
        end
      end
      ST_PAD: begin
        w_tx_en_nxt    = 1'b1;
        w_byte_cnt_nxt = w_byte_cnt_inc;
        if (w_byte_cnt_inc >= 11'(MIN_PAYLOAD)) begin
          w_step_nxt = 16'd0;
`ifdef GMII_TX_SCHED_FCS_EN
          w_state_nxt = ST_FCS;
`else
          w_state_nxt   = ST_IFG;
          w_tx_done_nxt = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_PAD;
        end
      end
`ifdef GMII_TX_SCHED_FCS_EN
      ST_FCS: begin
        w_tx_en_nxt = 1'b1;
        w_txd_nxt   = w_fcs_byte;
        if (r_step[1:0] == 2'd3) begin
          w_state_nxt   = ST_IFG;
          w_step_nxt    = 16'd0;
          w_tx_done_nxt = 1'b1;
        end else begin
          w_step_nxt = r_step + 16'd1;
        end
      end
`endif
      ST_IFG: begin
        w_rr_ptr_nxt = ~r_grant;
        if (r_step >= 16'(IFG_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = 16'd0;
        end else begin
          w_step_nxt = r_step + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (w_sel_valid && w_sel_last) begin
          w_state_nxt = ST_IFG;
          w_step_nxt  = 16'd0;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = 16'd0;
      end
    endcase
  end

  assign w_xfer_nxt = (w_state_nxt == ST_PAYLOAD) || (w_state_nxt == ST_DRAIN);

  // State, counters and registered outputs.
  always_ff @(posedge i_gmii_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_step      <= 16'd0;
      r_byte_cnt  <= 11'd0;
      r_txd       <= 8'h00;
      r_tx_en     <= 1'b0;
      r_tx_done   <= 1'b0;
      r_underrun  <= 1'b0;
      r_ch0_ready <= 1'b0;
      r_ch1_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_step      <= w_step_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_txd       <= w_txd_nxt;
      r_tx_en     <= w_tx_en_nxt;
      r_tx_done   <= w_tx_done_nxt;
      r_underrun  <= w_underrun_nxt;
      r_ch0_ready <= w_xfer_nxt & ~w_grant_nxt;
      r_ch1_ready <= w_xfer_nxt & w_grant_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_gmii_txd    = r_txd;
  assign o_gmii_tx_en  = r_tx_en;
  assign o_tx_done     = r_tx_done;
  assign o_tx_underrun = r_underrun;
  assign o_ch0_ready   = r_ch0_ready;
  assign o_ch1_ready   = r_ch1_ready;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Self-checking bench for gmii_tx_sched: random frames on both sources, compared against
// a frame-level model (arbitration order, wire bytes, padding, FCS when GMII_TX_SCHED_FCS_EN).
module tb_gmii_tx_sched;

  localparam int PRE_LEN = 7;
  localparam int IFG     = 12;
  localparam int MIN_PAY = 60;

  typedef struct packed {logic [7:0] d; logic l; logic drop;} beat_t;
  typedef struct packed {logic en; logic [7:0] d; logic done; logic urun; logic busy;} rec_t;
  typedef struct {int ch; int off; int len; int drop;} fd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat [2];
  logic       vld [2];
  logic       lst [2];
  logic       rdy [2];
  logic [7:0] txd;
  logic       tx_en, busy, tx_done, tx_urun;

  beat_t      q0[$], q1[$];
  rec_t       obs[$];
  logic [7:0] store[$];
  fd_t        pend[$];
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  bit         exp_abort[$];
  int         m_ptr = 0;
  bit         rec_on = 1'b0;
  logic [1:0] hs = 2'b00;
  int         tests = 0;
  int         fails = 0;

  gmii_tx_sched dut (
    .i_gmii_tx_clk (clk),
    .i_rst_n       (rst_n),
    .i_ch0_data    (dat[0]),
    .i_ch0_valid   (vld[0]),
    .i_ch0_last    (lst[0]),
    .o_ch0_ready   (rdy[0]),
    .i_ch1_data    (dat[1]),
    .i_ch1_valid   (vld[1]),
    .i_ch1_last    (lst[1]),
    .o_ch1_ready   (rdy[1]),
    .o_gmii_txd    (txd),
    .o_gmii_tx_en  (tx_en),
    .o_busy        (busy),
    .o_tx_done     (tx_done),
    .o_tx_underrun (tx_urun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int o, input int e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  // Source driver: handshake decided at the negedge before each posedge.
  initial begin : driver
    beat_t b;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!rst_n) begin
          hs[c] = 1'b0;
          vld[c] = 1'b0;
        end else begin
          if (hs[c]) begin
            if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
          hs[c] = 1'b0;
          if (qsize(c) > 0) begin
            b = (c == 0) ? q0[0] : q1[0];
            if (b.drop) begin
              vld[c] = 1'b0;
              if (c == 0) q0[0].drop = 1'b0; else q1[0].drop = 1'b0;
            end else begin
              vld[c] = 1'b1;
              dat[c] = b.d;
              lst[c] = b.l;
              hs[c]  = rdy[c];
            end
          end else begin
            vld[c] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rec_on) obs.push_back('{en: tx_en, d: txd, done: tx_done, urun: tx_urun, busy: busy});
    end
  end

  task automatic add_frame(input int c, input int len, input int drop, input bit ascii);
    fd_t fd;
    logic [7:0] d;
    fd.ch = c; fd.off = store.size(); fd.len = len; fd.drop = drop;
    for (int i = 0; i < len; i++) begin
      d = ascii ? (8'h31 + 8'(i)) : 8'($urandom);
      store.push_back(d);
      if (c == 0) q0.push_back('{d: d, l: (i == len - 1), drop: (i == drop)});
      else        q1.push_back('{d: d, l: (i == len - 1), drop: (i == drop)});
    end
    pend.push_back(fd);
  endtask

  // Expected wire image of one frame.
  task automatic emit(input fd_t fd);
    logic [7:0] body[$];
    logic [31:0] crc;
    for (int i = 0; i < PRE_LEN; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    if (fd.drop >= 0) begin
      for (int i = 0; i < fd.drop; i++) exp_bytes.push_back(store[fd.off + i]);
      exp_len.push_back(PRE_LEN + 1 + fd.drop);
      exp_abort.push_back(1'b1);
    end else begin
      for (int i = 0; i < fd.len; i++) body.push_back(store[fd.off + i]);
      while (body.size() < MIN_PAY) body.push_back(8'h00);
      foreach (body[i]) exp_bytes.push_back(body[i]);
      crc = 32'hFFFFFFFF;
      foreach (body[i]) begin
        crc = crc ^ {24'h000000, body[i]};
        for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
      end
      crc = ~crc;
`ifdef GMII_TX_SCHED_FCS_EN
      for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(crc >> (8 * k)));
      exp_len.push_back(PRE_LEN + 1 + body.size() + 4);
`else
      exp_len.push_back(PRE_LEN + 1 + body.size());
`endif
      exp_abort.push_back(1'b0);
    end
  endtask

  // Round-robin order: preferred channel if it has a frame, otherwise the other; then prefer the other.
  task automatic plan();
    int idx0[$];
    int idx1[$];
    int c;
    int f;
    exp_bytes.delete(); exp_len.delete(); exp_abort.delete();
    foreach (pend[i]) begin
      if (pend[i].ch == 0) idx0.push_back(i); else idx1.push_back(i);
    end
    while (idx0.size() + idx1.size() > 0) begin
      if (m_ptr == 0) c = (idx0.size() > 0) ? 0 : 1;
      else            c = (idx1.size() > 0) ? 1 : 0;
      f = (c == 0) ? idx0.pop_front() : idx1.pop_front();
      emit(pend[f]);
      m_ptr = (c == 0) ? 1 : 0;
    end
    pend.delete();
  endtask

  task automatic run_quiet(input string tag, input int max_cyc);
    int quiet = 0;
    int n = 0;
    obs.delete();
    rec_on = 1'b1;
    while (quiet < 4 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (q0.size() == 0 && q1.size() == 0 && !busy && !tx_en) quiet++; else quiet = 0;
    end
    rec_on = 1'b0;
    chk({tag, " completes"}, int'(quiet >= 4), 1);
  endtask

  task automatic analyze(input string tag);
    int bs[$];
    int be[$];
    int n_done = 0, n_urun = 0, bad_idle = 0, n_norm = 0, n_abort = 0, off = 0;
    int blen, bad, k, cnt;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i].en && (i == 0 || !obs[i-1].en)) bs.push_back(i);
      if (obs[i].en && (i == obs.size() - 1 || !obs[i+1].en)) be.push_back(i);
      if (!obs[i].en && obs[i].d !== 8'h00) bad_idle++;
      if (obs[i].done) n_done++;
      if (obs[i].urun) n_urun++;
    end
    foreach (exp_abort[f]) begin
      if (exp_abort[f]) n_abort++; else n_norm++;
    end
    chk({tag, " burst count"}, bs.size(), exp_len.size());
    chk({tag, " idle txd nonzero"}, bad_idle, 0);
    chk({tag, " tx_done count"}, n_done, n_norm);
    chk({tag, " underrun count"}, n_urun, n_abort);
    for (int f = 0; f < exp_len.size() && f < bs.size() && f < be.size(); f++) begin
      blen = be[f] - bs[f] + 1;
      bad = 0;
      chk($sformatf("%s frame%0d tx_en length", tag, f), blen, exp_len[f]);
      for (int j = 0; j < exp_len[f] && j < blen; j++) begin
        if (obs[bs[f] + j].d !== exp_bytes[off + j]) bad++;
      end
      chk($sformatf("%s frame%0d byte errors", tag, f), bad, 0);
      if (exp_abort[f]) begin
        chk($sformatf("%s frame%0d underrun after tx_en drop", tag, f),
            (be[f] + 1 < obs.size()) ? int'(obs[be[f] + 1].urun) : 0, 1);
      end else begin
        chk($sformatf("%s frame%0d tx_done on last byte", tag, f), int'(obs[be[f]].done), 1);
      end
      if (f > 0 && !exp_abort[f-1]) begin
        chk($sformatf("%s frame%0d ifg", tag, f), bs[f] - be[f-1] - 1, IFG);
      end
      off += exp_len[f];
    end
    if (be.size() > 0 && exp_abort.size() > 0 && !exp_abort[$]) begin
      k = be[be.size() - 1] + 1;
      cnt = 0;
      while (k < obs.size() && obs[k].busy) begin
        cnt++;
        k++;
      end
      chk({tag, " busy tail"}, cnt, IFG - 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " tx_en"}, int'(tx_en), 0);
    chk({tag, " txd"}, int'(txd), 0);
    chk({tag, " ready0"}, int'(rdy[0]), 0);
    chk({tag, " ready1"}, int'(rdy[1]), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done/underrun"}, int'({tx_done, tx_urun}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); pend.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int n;
    vld[0] = 1'b0; vld[1] = 1'b0;
    lst[0] = 1'b0; lst[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single 64-byte frame on ch0.
    add_frame(0, 64, -1, 1'b0);
    plan();
    run_quiet("t1", 3000);
    analyze("t1");

    // Both sources contend from reset: ch0 first, then alternation.
    do_reset();
    add_frame(1, $urandom_range(60, 80), -1, 1'b0);
    add_frame(0, $urandom_range(60, 80), -1, 1'b0);
    add_frame(1, $urandom_range(60, 80), -1, 1'b0);
    add_frame(0, $urandom_range(60, 80), -1, 1'b0);
    plan();
    run_quiet("t2", 6000);
    analyze("t2");

    // Padding boundaries plus random mix.
    add_frame(0, 10, -1, 1'b0);
    add_frame(1, 59, -1, 1'b0);
    add_frame(0, 60, -1, 1'b0);
    add_frame(1, 1, -1, 1'b0);
    for (int i = 0; i < 6; i++) add_frame(int'($urandom_range(0, 1)), $urandom_range(1, 90), -1, 1'b0);
    plan();
    run_quiet("t3", 12000);
    analyze("t3");

    // ch1 underruns after 20 bytes; later frames still correct.
    add_frame(1, 40, 20, 1'b0);
    add_frame(0, 30, -1, 1'b0);
    add_frame(1, 25, -1, 1'b0);
    plan();
    run_quiet("t5", 6000);
    analyze("t5");

    // Reset in the middle of a payload.
    add_frame(0, 100, -1, 1'b0);
    pend.delete();
    n = 0;
    while (!tx_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6 frame started", int'(tx_en), 1);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6 async reset");
    q0.delete(); q1.delete(); pend.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add_frame(0, 9, -1, 1'b1);
    add_frame(1, 70, -1, 1'b0);
    plan();
    run_quiet("t6", 4000);
    analyze("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
